// File: rtl/mem_stage_if.sv
// Data-memory request/completion bus between the MEM-stage controller (master)
// and the data memory (slave).
interface mem_stage_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one data-memory request per EX/MEM access, stalls the
// pipeline until completion or timeout. Optional macro ALIGN_CHECK_EN rejects odd addresses.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXMEM_valid,
  input  logic [15:0]       EXMEM_ALU,
  input  logic [15:0]       EXMEM_writeData,
  input  logic              EXMEM_MemRead,
  input  logic              EXMEM_MemWrt,
  mem_stage_if.master       mem,
  output logic [15:0]       MEM_readData,
  output logic              Done_DM,
  output logic              MMEM_err,
  output logic              Stall_DM
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic [1:0]  state_r;
  logic [1:0]  next_state_s;
  logic [7:0]  cnt_r;
  logic        err_r;
  logic        is_load_r;
  logic [15:0] rd_r;

  logic        access_s;
  logic        conflict_s;
  logic        misalign_s;
  logic        timeout_s;
  logic        mem_en_s;
  logic        done_s;
  logic        err_s;
  logic        stall_s;

  assign access_s   = EXMEM_valid & (EXMEM_MemRead | EXMEM_MemWrt);
  assign conflict_s = EXMEM_valid & EXMEM_MemRead & EXMEM_MemWrt;
`ifdef ALIGN_CHECK_EN
  assign misalign_s = access_s & EXMEM_ALU[0];
`else
  assign misalign_s = 1'b0;
`endif
  assign timeout_s  = (cnt_r == TO_LAST);

  // Output decode and next-state selection from current state and inputs.
  always_comb begin
    next_state_s = state_r;
    mem_en_s     = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    stall_s      = 1'b0;
    if (!rst) begin
      next_state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!access_s) begin
            done_s = 1'b1;
          end else if (conflict_s || misalign_s) begin
            done_s = 1'b1;
            err_s  = 1'b1;
          end else begin
            mem_en_s     = 1'b1;
            stall_s      = 1'b1;
            next_state_s = S_WAIT;
          end
        end
        S_WAIT: begin
          stall_s = 1'b1;
          // Completion beats a coincident timeout.
          if (mem.mem_done || timeout_s) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_WAIT;
          end
        end
        S_DONE: begin
          done_s       = 1'b1;
          err_s        = err_r;
          next_state_s = S_IDLE;
        end
        default: begin
          next_state_s = S_IDLE;
        end
      endcase
    end
  end

  // State, wait counter, error flag and read register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= 8'd0;
      err_r     <= 1'b0;
      is_load_r <= 1'b0;
      rd_r      <= 16'h0000;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        S_IDLE: begin
          if (mem_en_s) begin
            cnt_r     <= 8'd0;
            err_r     <= 1'b0;
            is_load_r <= EXMEM_MemRead;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_WAIT: begin
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 8'd1;
          end else begin
            cnt_r <= cnt_r;
          end
          if (mem.mem_done) begin
            err_r <= 1'b0;
            if (is_load_r) begin
              rd_r <= mem.mem_rdata;
            end else begin
              rd_r <= rd_r;
            end
          end else if (timeout_s) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
        end
        S_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign mem.mem_en    = mem_en_s;
  assign mem.mem_wr    = mem_en_s & EXMEM_MemWrt;
  assign mem.mem_addr  = mem_en_s ? EXMEM_ALU       : 16'h0000;
  assign mem.mem_wdata = mem_en_s ? EXMEM_writeData : 16'h0000;

  assign MEM_readData = rd_r;
  assign Done_DM      = done_s;
  assign MMEM_err     = err_s;
  assign Stall_DM     = stall_s;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a scoreboard of expected access results.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXMEM_valid;
  logic [15:0] EXMEM_ALU;
  logic [15:0] EXMEM_writeData;
  logic        EXMEM_MemRead;
  logic        EXMEM_MemWrt;
  logic [15:0] MEM_readData;
  logic        Done_DM;
  logic        MMEM_err;
  logic        Stall_DM;

  mem_stage_if mif ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .EXMEM_valid     (EXMEM_valid),
    .EXMEM_ALU       (EXMEM_ALU),
    .EXMEM_writeData (EXMEM_writeData),
    .EXMEM_MemRead   (EXMEM_MemRead),
    .EXMEM_MemWrt    (EXMEM_MemWrt),
    .mem             (mif.master),
    .MEM_readData    (MEM_readData),
    .Done_DM         (Done_DM),
    .MMEM_err        (MMEM_err),
    .Stall_DM        (Stall_DM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    EXMEM_valid   = 1'b0;
    EXMEM_MemRead = 1'b0;
    EXMEM_MemWrt  = 1'b0;
    mif.mem_done  = 1'b0;
  endtask

  // dly: cycles after the request cycle at which mem_done pulses (0 = never).
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input int dly, input logic [15:0] rdat);
    exp_t e;
    exp_t got;
    int   stalls;
    int   exp_stalls;
    logic found;
    logic ok;
    EXMEM_valid = 1'b1; EXMEM_MemRead = rd; EXMEM_MemWrt = wr;
    EXMEM_ALU = addr; EXMEM_writeData = wd;
    #2;
    chk({tag, " mem_en"}, {15'd0, mif.mem_en}, 16'h0001);
    chk({tag, " mem_wr"}, {15'd0, mif.mem_wr}, {15'd0, wr});
    chk({tag, " mem_addr"}, mif.mem_addr, addr);
    if (wr) chk({tag, " mem_wdata"}, mif.mem_wdata, wd);
    chk({tag, " req_done"}, {15'd0, Done_DM}, 16'h0000);
    ok = (dly >= 1) && (dly <= TO);
    e.rd  = (ok && rd) ? rdat : last_rd;
    e.err = !ok;
    exp_stalls = (ok ? dly : TO) + 1;
    sb.push_back(e);
    stalls = Stall_DM ? 1 : 0;
    found = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      mif.mem_done  = (k == dly);
      mif.mem_rdata = (k == dly) ? rdat : 16'hA5A5;
      #2;
      if (Done_DM) begin
        found = 1'b1;
        break;
      end
      if (Stall_DM) stalls++;
      if (mif.mem_en) chk({tag, " wait_mem_en"}, {15'd0, mif.mem_en}, 16'h0000);
    end
    chk({tag, " done_seen"}, {15'd0, found}, 16'h0001);
    got = sb.pop_front();
    chk({tag, " readData"}, MEM_readData, got.rd);
    chk({tag, " err"}, {15'd0, MMEM_err}, {15'd0, got.err});
    chk({tag, " stall_cycles"}, 16'(stalls), 16'(exp_stalls));
    last_rd = got.rd;
    cyc();
    clear_inputs();
    #2;
    chk({tag, " after_done"}, {14'd0, Done_DM, Stall_DM}, 16'h0002);
  endtask

  task automatic do_reject(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr);
    EXMEM_valid = 1'b1; EXMEM_MemRead = rd; EXMEM_MemWrt = wr; EXMEM_ALU = addr;
    #2;
    chk({tag, " mem_en"}, {15'd0, mif.mem_en}, 16'h0000);
    chk({tag, " done/err/stall"}, {13'd0, Done_DM, MMEM_err, Stall_DM}, 16'h0006);
    cyc();
    clear_inputs();
    #2;
    chk({tag, " idle_after"}, {13'd0, Done_DM, MMEM_err, Stall_DM}, 16'h0004);
    chk({tag, " readData"}, MEM_readData, last_rd);
  endtask

  initial begin
    rst = 1'b0;
    EXMEM_ALU = 16'h0000; EXMEM_writeData = 16'h0000;
    mif.mem_rdata = 16'h0000;
    clear_inputs();
    #2;
    chk("rst_outs", {12'd0, Done_DM, MMEM_err, Stall_DM, mif.mem_en}, 16'h0000);
    cyc(); cyc();
    rst = 1'b1;
    #2;
    chk("rst_readData", MEM_readData, 16'h0000);
    chk("rst_idle", {14'd0, Done_DM, Stall_DM}, 16'h0002);
    last_rd = 16'h0000;

    do_access("load40", 1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'hBEEF);
    do_access("store10", 1'b0, 1'b1, 16'h0010, 16'h1234, 1, 16'h7777);
    do_access("timeout", 1'b1, 1'b0, 16'h0020, 16'h0000, 0, 16'h0000);
    do_access("load_min", 1'b1, 1'b0, 16'h0022, 16'h0000, 1, 16'h5A5A);
    do_access("done_at_to", 1'b1, 1'b0, 16'h0024, 16'h0000, TO, 16'hC3C3);
    do_access("store_to", 1'b0, 1'b1, 16'h0030, 16'h4321, 0, 16'h0000);
    do_reject("rd_and_wr", 1'b1, 1'b1, 16'h0050);
`ifdef ALIGN_CHECK_EN
    do_reject("misalign", 1'b1, 1'b0, 16'h0041);
`else
    do_access("misalign", 1'b1, 1'b0, 16'h0041, 16'h0000, 1, 16'h0F0F);
`endif

    // Stray mem_done in IDLE must not touch the read register.
    mif.mem_done = 1'b1; mif.mem_rdata = 16'hDEAD;
    cyc();
    mif.mem_done = 1'b0;
    #2;
    chk("idle_done_ignored", MEM_readData, last_rd);

    // Reset in WAIT abandons the access; the late completion is ignored.
    EXMEM_valid = 1'b1; EXMEM_MemRead = 1'b1; EXMEM_ALU = 16'h0060;
    cyc();
    #2;
    chk("rw_in_wait", {14'd0, Done_DM, Stall_DM}, 16'h0001);
    rst = 1'b0;
    #1;
    chk("rw_rst_outs", {12'd0, Done_DM, MMEM_err, Stall_DM, mif.mem_en}, 16'h0000);
    cyc();
    rst = 1'b1;
    clear_inputs();
    mif.mem_done = 1'b1; mif.mem_rdata = 16'hDEAD;
    #2;
    chk("rw_idle", {14'd0, Done_DM, Stall_DM}, 16'h0002);
    cyc();
    mif.mem_done = 1'b0;
    #2;
    chk("rw_readData", MEM_readData, 16'h0000);
    chk("rw_still_idle", {14'd0, Done_DM, Stall_DM}, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 15, maximum cycles waited for mem_done before the access is aborted with error; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-low reset; sampled on the rising clk edge.
REQ-004 EXMEM_valid  in  1  instruction in EX/MEM slot is valid; 0 means no access.
REQ-005 EXMEM_ALU  in  16  byte address of the access.
REQ-006 EXMEM_writeData  in  16  store data.
REQ-007 EXMEM_MemRead / EXMEM_MemWrt  in  1 each  load / store request.
REQ-008 mem_en, mem_wr  out  1 each  one-cycle request strobe to data memory, and write qualifier.
REQ-009 mem_addr, mem_wdata  out  16 each  request address and data, valid while mem_en=1.
REQ-010 mem_done  in  1  memory completion pulse; mem_rdata (in, 16) is valid in the same cycle.
REQ-011 MEM_readData  out  16  load result presented to the DM/WB latch.
REQ-012 Done_DM  out  1  the access in the EX/MEM slot is complete this cycle.
REQ-013 MMEM_err  out  1  memory-stage exception for the access, valid when Done_DM=1.
REQ-014 Stall_DM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM latches this cycle.

Function
REQ-015 FSM states: IDLE, WAIT, DONE; one-hot or binary encoding is an implementation choice.
REQ-016 IDLE, no access (EXMEM_valid=0, or MemRead=MemWrt=0): Done_DM=1, Stall_DM=0, mem_en=0, MMEM_err=0, remain in IDLE.
REQ-017 IDLE, MemRead=1 and MemWrt=1 with EXMEM_valid=1: no request; Done_DM=1, MMEM_err=1, Stall_DM=0, remain in IDLE.
REQ-018 IDLE, legal access: mem_en=1 for exactly this cycle; mem_wr=MemWrt; mem_addr=EXMEM_ALU; mem_wdata=EXMEM_writeData; Stall_DM=1; Done_DM=0; next state WAIT; wait counter cleared to 0.
REQ-019 WAIT: Stall_DM=1, Done_DM=0, mem_en=0; counter increments by 1 per cycle; counter saturates and does not wrap.
REQ-020 WAIT, mem_done=1: capture mem_rdata into the read register (captured only for loads); next state DONE, error flag cleared.
REQ-021 WAIT, mem_done=0 and counter equal to TIMEOUT_CYCLES-1: next state DONE, error flag set; read register unchanged.
REQ-022 mem_done and timeout in the same cycle: mem_done wins, with no error.
REQ-023 DONE: Done_DM=1, Stall_DM=0, MMEM_err=error flag, MEM_readData=read register; next state IDLE unconditionally; the EX/MEM latch advances on this edge.
REQ-024 mem_done is ignored in IDLE and DONE; mem_done is never expected in the request cycle, so minimum access latency is 3 cycles (request, WAIT, DONE).
REQ-025 MEM_readData holds its last value in every state except the cycle after a capture; stores leave it unchanged.
REQ-026 Outputs Done_DM, Stall_DM, MMEM_err and mem_en are decoded from state and current inputs; no output is registered beyond the read register and the error flag.

Reset
REQ-027 rst=0 at a clock edge: state<=IDLE, counter<=0, error flag<=0, read register<=16'h0000.
REQ-028 While rst=0: mem_en=0, Stall_DM=0, Done_DM=0, MMEM_err=0.
REQ-029 Reset in WAIT or DONE abandons the access; a later mem_done for it is ignored (state IDLE).

Configuration
REQ-030 Macro ALIGN_CHECK_EN defined: a legal access with EXMEM_ALU[0]=1 issues no request; Done_DM=1, MMEM_err=1 in the same cycle, remain in IDLE.
REQ-031 ALIGN_CHECK_EN undefined: address bit 0 is not checked; the access proceeds per REQ-018 with mem_addr unmodified.

Verification
REQ-032 Reset then idle: rst=0 2 cycles, MemRead=0 -> MEM_readData=0000, Done_DM=1, Stall_DM=0 after release.
REQ-033 Load addr 0x0040, mem_done 2 cycles after mem_en with rdata 0xBEEF -> mem_en 1 cycle, Stall_DM high 3 cycles, DONE: MEM_readData=BEEF, MMEM_err=0.
REQ-034 Store addr 0x0010 data 0x1234 -> mem_en=1, mem_wr=1, mem_wdata=1234; MEM_readData unchanged after DONE.
REQ-035 Load, mem_done never asserted, TIMEOUT_CYCLES=4 -> DONE after 4 WAIT cycles, MMEM_err=1, Done_DM=1 one cycle.
REQ-036 Load addr 0x0041 -> with ALIGN_CHECK_EN: no mem_en, MMEM_err=1, Done_DM=1 same cycle; without it: normal 3+-cycle access.
REQ-037 rst=0 during WAIT, mem_done pulsed the next cycle -> state IDLE, no DONE cycle, MEM_readData=0000.
